// File: rtl/led_pwm_pkg.sv
// Shared definitions for the multi-channel LED PWM fader: the channel mode
// encoding and the helpers that size the counters and the channel select.
package led_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC  = 2'd0,
        MODE_BREATHE = 2'd1,
        MODE_FADE    = 2'd2,
        MODE_OFF     = 2'd3
    } led_mode_e;

    // Width of the channel select; a single channel still needs one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: shadow command register, active level/direction, the
// per-mode level update applied at period starts, and the PWM compare flop.
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int P_PWM_BITS   = 8,
    parameter bit P_ACTIVE_LOW = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  led_mode_e             i_wr_mode,
    input  logic [P_PWM_BITS-1:0] i_wr_duty,
    input  logic                  i_period_start,
    input  logic                  i_fade_step,
    input  logic [P_PWM_BITS-1:0] i_pwm_cnt,
    output logic                  o_led
);

    localparam logic [P_PWM_BITS-1:0] LVL_MAX = '1;
    localparam logic [P_PWM_BITS-1:0] LVL_ONE = {{(P_PWM_BITS-1){1'b0}}, 1'b1};

    led_mode_e             mode_q, mode_d;
    logic [P_PWM_BITS-1:0] target_q, target_d;
    logic                  pending_q, pending_d;
    led_mode_e             act_mode_q, act_mode_d;
    logic [P_PWM_BITS-1:0] act_target_q, act_target_d;
    logic [P_PWM_BITS-1:0] level_q, level_d;
    logic                  dir_up_q, dir_up_d;
    logic                  led_q, led_d;

    // The fade step sees the freshly copied mode/level, so a command and the
    // first step can land on the same period start.
    always_comb begin
        mode_d       = mode_q;
        target_d     = target_q;
        pending_d    = pending_q;
        act_mode_d   = act_mode_q;
        act_target_d = act_target_q;
        level_d      = level_q;
        dir_up_d     = dir_up_q;

        if (i_period_start) begin
            if (pending_q) begin
                act_mode_d   = mode_q;
                act_target_d = target_q;
                dir_up_d     = 1'b1;
                pending_d    = 1'b0;
                case (mode_q)
                    MODE_STATIC: level_d = target_q;
                    MODE_OFF:    level_d = '0;
                    default:     level_d = level_q;
                endcase
            end

            if (i_fade_step) begin
                case (act_mode_d)
                    MODE_BREATHE: begin
                        if (dir_up_d) begin
                            if (level_d == LVL_MAX) begin
                                level_d  = LVL_MAX - LVL_ONE;
                                dir_up_d = 1'b0;
                            end else begin
                                level_d = level_d + LVL_ONE;
                                if (level_d == LVL_MAX) dir_up_d = 1'b0;
                            end
                        end else begin
                            if (level_d == '0) begin
                                level_d  = LVL_ONE;
                                dir_up_d = 1'b1;
                            end else begin
                                level_d = level_d - LVL_ONE;
                                if (level_d == '0) dir_up_d = 1'b1;
                            end
                        end
                    end
                    MODE_FADE: begin
                        if (level_d < act_target_d)      level_d = level_d + LVL_ONE;
                        else if (level_d > act_target_d) level_d = level_d - LVL_ONE;
                    end
                    default: level_d = level_d;
                endcase
            end
        end

        // A write on the period-start cycle still wins the pending flag, so it
        // is picked up at the following period start.
        if (i_wr_en) begin
            mode_d    = i_wr_mode;
            target_d  = i_wr_duty;
            pending_d = 1'b1;
        end

        led_d = (i_pwm_cnt < level_q) ^ P_ACTIVE_LOW;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode_q       <= MODE_STATIC;
            target_q     <= '0;
            pending_q    <= 1'b0;
            act_mode_q   <= MODE_STATIC;
            act_target_q <= '0;
            level_q      <= '0;
            dir_up_q     <= 1'b1;
            led_q        <= P_ACTIVE_LOW;
        end else begin
            mode_q       <= mode_d;
            target_q     <= target_d;
            pending_q    <= pending_d;
            act_mode_q   <= act_mode_d;
            act_target_q <= act_target_d;
            level_q      <= level_d;
            dir_up_q     <= dir_up_d;
            led_q        <= led_d;
        end
    end

    assign o_led = led_q;

endmodule

// File: rtl/led_pwm_fader.sv
// Multi-channel PWM LED driver: shared prescaler, PWM counter and fade divider
// feeding one led_pwm_channel per LED, plus the command write decode.
module led_pwm_fader
    import led_pwm_pkg::*;
#(
    parameter int P_CHANNELS     = 3,
    parameter int P_PWM_BITS     = 8,
    parameter int P_PRESCALE     = 16,
    parameter int P_FADE_PERIODS = 4,
    parameter bit P_ACTIVE_LOW   = 1'b1
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_wr_en,
    input  logic [ch_width(P_CHANNELS)-1:0]    i_wr_ch,
    input  logic [1:0]                         i_wr_mode,
    input  logic [P_PWM_BITS-1:0]              i_wr_duty,
    output logic [P_CHANNELS-1:0]              o_led,
    output logic                               o_period_start
);

    localparam int CW = ch_width(P_CHANNELS);
    localparam int PW = cnt_width(P_PRESCALE);
    localparam int FW = cnt_width(P_FADE_PERIODS);

    localparam logic [PW-1:0]         PRESC_LAST = PW'(P_PRESCALE - 1);
    localparam logic [PW-1:0]         PRESC_ONE  = PW'(1);
    localparam logic [FW-1:0]         FADE_LAST  = FW'(P_FADE_PERIODS - 1);
    localparam logic [FW-1:0]         FADE_ONE   = FW'(1);
    localparam logic [P_PWM_BITS-1:0] PWM_LAST   = {{(P_PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [P_PWM_BITS-1:0] PWM_ONE    = {{(P_PWM_BITS-1){1'b0}}, 1'b1};

    logic [PW-1:0]         presc_q, presc_d;
    logic [P_PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [FW-1:0]         fade_cnt_q, fade_cnt_d;
    logic                  period_start_q, period_start_d;
    logic                  tick;
    logic                  wrap;
    logic                  fade_step;
    logic                  wr_valid;

    // The PWM period is 2^B-1 ticks so that a full-scale level is lit on every tick.
    always_comb begin
        tick      = (presc_q == PRESC_LAST);
        wrap      = tick && (pwm_cnt_q == PWM_LAST);
        fade_step = wrap && (fade_cnt_q == FADE_LAST);

        presc_d   = tick ? '0 : presc_q + PRESC_ONE;

        pwm_cnt_d = pwm_cnt_q;
        if (tick) pwm_cnt_d = wrap ? '0 : pwm_cnt_q + PWM_ONE;

        fade_cnt_d = fade_cnt_q;
        if (wrap) fade_cnt_d = fade_step ? '0 : fade_cnt_q + FADE_ONE;

        period_start_d = wrap;
        wr_valid       = i_wr_en && (32'(i_wr_ch) < P_CHANNELS);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            presc_q        <= '0;
            pwm_cnt_q      <= '0;
            fade_cnt_q     <= '0;
            period_start_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            pwm_cnt_q      <= pwm_cnt_d;
            fade_cnt_q     <= fade_cnt_d;
            period_start_q <= period_start_d;
        end
    end

    assign o_period_start = period_start_q;

    for (genvar c = 0; c < P_CHANNELS; c++) begin : g_ch
        led_pwm_channel #(
            .P_PWM_BITS   (P_PWM_BITS),
            .P_ACTIVE_LOW (P_ACTIVE_LOW)
        ) u_ch (
            .i_clk          (i_clk),
            .i_rst          (i_rst),
            .i_wr_en        (wr_valid && (i_wr_ch == CW'(c))),
            .i_wr_mode      (led_mode_e'(i_wr_mode)),
            .i_wr_duty      (i_wr_duty),
            .i_period_start (wrap),
            .i_fade_step    (fade_step),
            .i_pwm_cnt      (pwm_cnt_q),
            .o_led          (o_led[c])
        );
    end

endmodule
